// File: rtl/core_csr_file.sv
// Control/status register file with free-running machine counters (cycle, time,
// instret, hpm) readable through both user read-only and machine read-write aliases.
module core_csr_file #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2 * DATA_WIDTH,
  parameter int NUM_HPM    = 4,
  parameter int TIME_DIV   = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [11:0]                             csr_addr_i,
  input  logic [1:0]                              csr_op_i,
  input  logic [DATA_WIDTH-1:0]                   csr_wdata_i,
  output logic [DATA_WIDTH-1:0]                   csr_rdata_o,
  output logic                                    csr_illegal_o,
  input  logic                                    retire_i,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0]  hpm_event_i
);

  // Counter slots: 0 cycle, 1 time, 2 instret, 3.. hpm channels.
  localparam int NUM_CNT = 3 + NUM_HPM;
  localparam int PRE_W   = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [DATA_WIDTH-1:0] INH_MASK =
    DATA_WIDTH'((((64'd1 << NUM_HPM) - 64'd1) << 3) | 64'd5);

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0]    inc;
  logic [NUM_CNT-1:0]    cnt_sel;
  logic                  cnt_hi;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic                  time_tick;
  logic [DATA_WIDTH-1:0] ustatus_q, mscratch_q, minhibit_q;
  logic                  mapped, read_only;
  logic                  sel_ustatus, sel_mscratch, sel_minhibit;
  logic [DATA_WIDTH-1:0] rdata, wr_val;
  logic                  wr_en;

  always_comb begin
    mapped       = 1'b0;
    read_only    = 1'b0;
    cnt_sel      = '0;
    cnt_hi       = 1'b0;
    sel_ustatus  = 1'b0;
    sel_mscratch = 1'b0;
    sel_minhibit = 1'b0;
    rdata        = '0;
    case (csr_addr_i)
      12'h000: begin mapped = 1'b1; sel_ustatus  = 1'b1; rdata = ustatus_q;  end
      12'h340: begin mapped = 1'b1; sel_mscratch = 1'b1; rdata = mscratch_q; end
      12'h320: begin mapped = 1'b1; sel_minhibit = 1'b1; rdata = minhibit_q; end
      default: ;
    endcase
    // Bit 7 of the address picks the high half in both alias ranges.
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_addr_i == 12'(12'hC00 + i) || csr_addr_i == 12'(12'hC80 + i)) begin
        mapped     = 1'b1;
        read_only  = 1'b1;
        cnt_sel[i] = 1'b1;
        cnt_hi     = csr_addr_i[7];
      end
      if (i != 1 && (csr_addr_i == 12'(12'hB00 + i) || csr_addr_i == 12'(12'hB80 + i))) begin
        mapped     = 1'b1;
        cnt_sel[i] = 1'b1;
        cnt_hi     = csr_addr_i[7];
      end
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (cnt_sel[i]) begin
        rdata = cnt_hi ? cnt_q[i][CNT_WIDTH-1:DATA_WIDTH] : cnt_q[i][DATA_WIDTH-1:0];
      end
    end
  end

  assign csr_rdata_o   = rdata;
  assign csr_illegal_o = !mapped || (read_only && csr_op_i != 2'b00);
  assign wr_en         = (csr_op_i != 2'b00) && !csr_illegal_o;

  always_comb begin
    case (csr_op_i)
      2'b01:   wr_val = csr_wdata_i;
      2'b10:   wr_val = rdata | csr_wdata_i;
      2'b11:   wr_val = rdata & ~csr_wdata_i;
      default: wr_val = rdata;
    endcase
  end

  assign time_tick = (presc_q == PRE_W'(TIME_DIV - 1));
  assign presc_d   = time_tick ? '0 : presc_q + PRE_W'(1);

  // Increments use the registered inhibit, so an inhibit write only takes effect next edge.
  always_comb begin
    inc    = '0;
    inc[0] = ~minhibit_q[0];
    inc[1] = time_tick;
    inc[2] = retire_i & ~minhibit_q[2];
    for (int k = 0; k < NUM_HPM; k++) begin
      inc[3+k] = hpm_event_i[k] & ~minhibit_q[3+k];
    end
  end

  // A write to either half suppresses that counter's increment entirely.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_en && cnt_sel[i]) begin
        if (cnt_hi) cnt_d[i][CNT_WIDTH-1:DATA_WIDTH] = wr_val;
        else        cnt_d[i][DATA_WIDTH-1:0]         = wr_val;
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      presc_q    <= '0;
      ustatus_q  <= '0;
      mscratch_q <= '0;
      minhibit_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
      presc_q <= presc_d;
      if (wr_en && sel_ustatus)  ustatus_q  <= wr_val;
      if (wr_en && sel_mscratch) mscratch_q <= wr_val;
      if (wr_en && sel_minhibit) minhibit_q <= wr_val & INH_MASK;
    end
  end

endmodule

// File: tb/tb_core_csr_file.sv
// Self-checking bench for core_csr_file: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_core_csr_file;
  localparam int DW = 32;
  localparam int NH = 4;
  localparam int TD = 4;
  localparam int NC = 3 + NH;
  localparam logic [31:0] M_INH = 32'h5 | (((32'd1 << NH) - 32'd1) << 3);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   csr_addr = '0;
  logic [1:0]    csr_op = '0;
  logic [DW-1:0] csr_wdata = '0;
  logic [DW-1:0] csr_rdata;
  logic          csr_illegal;
  logic          retire = 1'b0;
  logic [NH-1:0] hpm_ev = '0;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_cnt [NC];
  int          m_presc;
  logic [31:0] m_ust, m_msc, m_inh;

  // Clock / reset
  always #10 clk = ~clk;

  core_csr_file #(.DATA_WIDTH(DW), .NUM_HPM(NH), .TIME_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_addr_i   (csr_addr),
    .csr_op_i     (csr_op),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (csr_rdata),
    .csr_illegal_o(csr_illegal),
    .retire_i     (retire),
    .hpm_event_i  (hpm_ev)
  );

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = '0;
    m_presc = 0;
    m_ust = '0; m_msc = '0; m_inh = '0;
  endtask

  function automatic void m_read(input logic [11:0] a, output logic [31:0] d,
                                 output logic mp, output logic ro);
    int off;
    d = '0; mp = 1'b0; ro = 1'b0;
    off = int'(a[6:0]);
    if (a == 12'h000) begin d = m_ust; mp = 1'b1; end
    else if (a == 12'h340) begin d = m_msc; mp = 1'b1; end
    else if (a == 12'h320) begin d = m_inh; mp = 1'b1; end
    else if ((a[11:8] == 4'hC || a[11:8] == 4'hB) && off < NC &&
             !(a[11:8] == 4'hB && off == 1)) begin
      mp = 1'b1;
      ro = (a[11:8] == 4'hC);
      d  = a[7] ? m_cnt[off][63:32] : m_cnt[off][31:0];
    end
  endfunction

  task automatic model_step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                            input logic ret, input logic [NH-1:0] ev);
    logic [31:0] old, res;
    logic        mp, ro, ill;
    logic [63:0] nxt [NC];
    int          idx;
    m_read(a, old, mp, ro);
    ill = !mp || (ro && op != 2'b00);
    for (int i = 0; i < NC; i++) nxt[i] = m_cnt[i];
    if (!m_inh[0]) nxt[0] = nxt[0] + 64'd1;
    if (m_presc == TD - 1) begin m_presc = 0; nxt[1] = nxt[1] + 64'd1; end
    else m_presc = m_presc + 1;
    if (ret && !m_inh[2]) nxt[2] = nxt[2] + 64'd1;
    for (int k = 0; k < NH; k++) if (ev[k] && !m_inh[3+k]) nxt[3+k] = nxt[3+k] + 64'd1;
    if (op != 2'b00 && !ill) begin
      case (op)
        2'b01:   res = wd;
        2'b10:   res = old | wd;
        default: res = old & ~wd;
      endcase
      if (a == 12'h000) m_ust = res;
      else if (a == 12'h340) m_msc = res;
      else if (a == 12'h320) m_inh = res & M_INH;
      else begin
        idx = int'(a[6:0]);
        if (a[7]) nxt[idx] = {res, m_cnt[idx][31:0]};
        else      nxt[idx] = {m_cnt[idx][63:32], res};
      end
    end
    for (int i = 0; i < NC; i++) m_cnt[i] = nxt[i];
  endtask

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step(csr_addr, csr_op, csr_wdata, retire, hpm_ev);
    @(negedge clk);
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] d, output logic il);
    csr_op = 2'b00;
    csr_addr = a;
    #1;
    d = csr_rdata;
    il = csr_illegal;
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 12'h000;
      1:       return 12'h340;
      2:       return 12'h320;
      3, 6:    return {4'hC, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 8))};
      4, 7:    return {4'hB, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 8))};
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic        il;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    peek(12'hC00, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_cycle got=%h exp=%h", d, 32'd0); end
    peek(12'h320, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_inhibit got=%h exp=%h", d, 32'd0); end
    rst = 1'b0;
    cycle();
    peek(12'hC00, d, il);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL first_edge_cycle got=%h exp=%h", d, 32'd1); end
    repeat (9) cycle();
    peek(12'hC00, d, il);
    checks++; if (d !== 32'd10) begin failures++; $display("FAIL idle_cycle got=%h exp=%h", d, 32'd10); end
    peek(12'hC02, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL idle_instret got=%h exp=%h", d, 32'd0); end
    peek(12'hC01, d, il);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL idle_time got=%h exp=%h", d, 32'd2); end
    peek(12'hC80, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL idle_cycleh got=%h exp=%h", d, 32'd0); end
  endtask

  task automatic test_carry();
    logic [31:0] d;
    logic        il;
    csr_addr = 12'hB00; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF;
    cycle();
    csr_addr = 12'hB80; csr_op = 2'b01; csr_wdata = 32'h0;
    cycle();
    peek(12'hC00, d, il);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL carry_lo_held got=%h exp=%h", d, 32'hFFFF_FFFF); end
    peek(12'hC80, d, il);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL carry_hi_written got=%h exp=%h", d, 32'h0); end
    cycle();
    peek(12'hC80, d, il);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL carry_cycleh got=%h exp=%h", d, 32'd1); end
    peek(12'hC00, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL carry_cycle got=%h exp=%h", d, 32'd0); end
  endtask

  task automatic test_inhibit();
    logic [31:0] d, snap_c, snap_i;
    logic        il;
    csr_addr = 12'h320; csr_op = 2'b10; csr_wdata = 32'h5;
    cycle();
    peek(12'h320, d, il);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL inhibit_set got=%h exp=%h", d, 32'h5); end
    peek(12'hC00, snap_c, il);
    peek(12'hC02, snap_i, il);
    retire = 1'b1;
    repeat (8) cycle();
    peek(12'hC00, d, il);
    checks++; if (d !== snap_c) begin failures++; $display("FAIL inhibit_cycle got=%h exp=%h", d, snap_c); end
    peek(12'hC02, d, il);
    checks++; if (d !== snap_i) begin failures++; $display("FAIL inhibit_instret got=%h exp=%h", d, snap_i); end
    peek(12'hC01, d, il);
    checks++; if (d !== m_cnt[1][31:0]) begin failures++; $display("FAIL inhibit_time got=%h exp=%h", d, m_cnt[1][31:0]); end
    csr_addr = 12'h320; csr_op = 2'b11; csr_wdata = 32'h5;
    cycle();
    csr_op = 2'b00;
    repeat (4) cycle();
    retire = 1'b0;
    peek(12'hC00, d, il);
    checks++; if (d !== snap_c + 32'd4) begin failures++; $display("FAIL resume_cycle got=%h exp=%h", d, snap_c + 32'd4); end
    peek(12'hC02, d, il);
    checks++; if (d !== snap_i + 32'd4) begin failures++; $display("FAIL resume_instret got=%h exp=%h", d, snap_i + 32'd4); end
  endtask

  task automatic test_illegal();
    logic [31:0] d, c0;
    logic        il;
    peek(12'hC00, c0, il);
    csr_addr = 12'hC00; csr_op = 2'b01; csr_wdata = 32'h1234;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin failures++; $display("FAIL ro_write_illegal got=%b exp=1", csr_illegal); end
    cycle();
    peek(12'hC00, d, il);
    checks++; if (d !== c0 + 32'd1) begin failures++; $display("FAIL ro_write_cycle got=%h exp=%h", d, c0 + 32'd1); end
    peek(12'h7FF, d, il);
    checks++; if (d !== 32'd0 || il !== 1'b1) begin failures++; $display("FAIL unmapped_read got=%h/%b exp=0/1", d, il); end
    peek(12'hB01, d, il);
    checks++; if (il !== 1'b1) begin failures++; $display("FAIL no_mtime_alias got=%b exp=1", il); end
    peek(12'hC07, d, il);
    checks++; if (il !== 1'b1) begin failures++; $display("FAIL hpm_out_of_range got=%b exp=1", il); end
    peek(12'h000, d, il);
    checks++; if (il !== 1'b0) begin failures++; $display("FAIL ustatus_legal got=%b exp=0", il); end
  endtask

  task automatic test_write_wins();
    logic [31:0] d;
    logic        il;
    csr_addr = 12'hB02; csr_op = 2'b01; csr_wdata = 32'h100; retire = 1'b1;
    cycle();
    retire = 1'b0;
    peek(12'hC02, d, il);
    checks++; if (d !== 32'h100) begin failures++; $display("FAIL minstret_wins got=%h exp=%h", d, 32'h100); end
    csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'h0F;
    cycle();
    csr_addr = 12'h340; csr_op = 2'b10; csr_wdata = 32'hF0;
    cycle();
    peek(12'h340, d, il);
    checks++; if (d !== 32'hFF) begin failures++; $display("FAIL mscratch_set got=%h exp=%h", d, 32'hFF); end
    csr_addr = 12'h340; csr_op = 2'b11; csr_wdata = 32'h0F;
    cycle();
    peek(12'h340, d, il);
    checks++; if (d !== 32'hF0) begin failures++; $display("FAIL mscratch_clear got=%h exp=%h", d, 32'hF0); end
  endtask

  task automatic test_random();
    logic [31:0] exp_d;
    logic        mp, ro, exp_il;
    for (int n = 0; n < 400; n++) begin
      csr_addr  = rand_addr();
      csr_op    = 2'($urandom_range(0, 3));
      csr_wdata = $urandom;
      retire    = 1'($urandom_range(0, 1));
      hpm_ev    = NH'($urandom);
      #1;
      m_read(csr_addr, exp_d, mp, ro);
      exp_il = !mp || (ro && csr_op != 2'b00);
      checks++; if (csr_rdata !== exp_d) begin failures++; $display("FAIL rand_rdata addr=%h got=%h exp=%h", csr_addr, csr_rdata, exp_d); end
      checks++; if (csr_illegal !== exp_il) begin failures++; $display("FAIL rand_illegal addr=%h op=%0d got=%b exp=%b", csr_addr, csr_op, csr_illegal, exp_il); end
      cycle();
    end
    csr_op = 2'b00; retire = 1'b0; hpm_ev = '0;
    // leave inhibit clear so later scenarios see live counters
    csr_addr = 12'h320; csr_op = 2'b01; csr_wdata = 32'h0;
    cycle();
    csr_op = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        il;
    csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'hDEAD_BEEF;
    hpm_ev = '1; retire = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (csr_rdata !== 32'd0) begin failures++; $display("FAIL async_rst_rdata got=%h exp=%h", csr_rdata, 32'd0); end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    peek(12'h340, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_mscratch got=%h exp=%h", d, 32'd0); end
    peek(12'hC03, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_hpm3 got=%h exp=%h", d, 32'd0); end
    peek(12'hC06, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_hpm6 got=%h exp=%h", d, 32'd0); end
    peek(12'hC00, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_cycle_mid got=%h exp=%h", d, 32'd0); end
    hpm_ev = '0; retire = 1'b0;
    rst = 1'b0;
    peek(12'h340, d, il);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_no_commit got=%h exp=%h", d, 32'd0); end
    cycle();
    peek(12'hC00, d, il);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL rerelease_cycle got=%h exp=%h", d, 32'd1); end
    peek(12'hC03, d, il);
    checks++; if (d !== m_cnt[3][31:0]) begin failures++; $display("FAIL rerelease_hpm3 got=%h exp=%h", d, m_cnt[3][31:0]); end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_inhibit();
    test_illegal();
    test_write_wins();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
